// File: rtl/lcs_engine.sv
// ============================================================================
// Module  : lcs_engine
// Brief   : Longest-common-subsequence engine for the text-entry result
//           screens. Fills a DP table one cell per clock, then traces back
//           one step per clock, producing the LCS length and a space-padded,
//           left-justified LCS string ready for an LCD row.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lcs_engine #(
  parameter int MAXLEN = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [8*MAXLEN-1:0]   str_a,
  input  logic [4:0]            len_a,
  input  logic [8*MAXLEN-1:0]   str_b,
  input  logic [4:0]            len_b,
  output logic                  busy,
  output logic                  done,
  output logic [4:0]            lcs_len,
  output logic [8*MAXLEN-1:0]   lcs_str
);

  localparam int              c_W        = 8 * MAXLEN;
  localparam logic [4:0]      c_MAX      = 5'(MAXLEN);
  localparam logic [c_W-1:0]  c_SPACES   = {MAXLEN{8'h20}};
  // Byte mask over character slot 0 (the MSBs); shifted right to reach slot k.
  localparam logic [c_W-1:0]  c_TOP_MASK = ~({c_W{1'b1}} >> 8);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_TRACE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]      r_state;
  logic [c_W-1:0]  r_str_a;
  logic [c_W-1:0]  r_str_b;
  logic [4:0]      r_la;
  logic [4:0]      r_lb;
  logic [4:0]      r_i;
  logic [4:0]      r_j;
  logic [4:0]      r_lcs_len;
  logic [c_W-1:0]  r_lcs_str;

  // Row 0 and column 0 are never written; the read logic substitutes zero.
  logic [4:0]      r_dp [0:MAXLEN][0:MAXLEN];

  logic [4:0]      w_im1;
  logic [4:0]      w_jm1;
  logic [7:0]      w_a_ch;
  logic [7:0]      w_b_ch;
  logic            w_match;
  logic [4:0]      w_diag;
  logic [4:0]      w_up;
  logic [4:0]      w_left;
  logic [4:0]      w_cur;
  logic [4:0]      w_max;
  logic [4:0]      w_cell;
  logic [4:0]      w_slot;
  logic [c_W-1:0]  w_slot_mask;
  logic [c_W-1:0]  w_slot_char;
  logic [c_W-1:0]  w_sh_a;
  logic [c_W-1:0]  w_sh_b;

  assign w_im1 = r_i - 5'd1;
  assign w_jm1 = r_j - 5'd1;

  // Character k of a string sits at the MSB end after shifting left by 8k.
  assign w_sh_a = r_str_a << {w_im1, 3'b000};
  assign w_sh_b = r_str_b << {w_jm1, 3'b000};
  assign w_a_ch = w_sh_a[c_W-1 -: 8];
  assign w_b_ch = w_sh_b[c_W-1 -: 8];
  assign w_match = (w_a_ch == w_b_ch);

  // Neighbouring DP reads around (i,j); boundary row/column read as zero.
  always_comb begin
    w_diag = 5'd0;
    w_up   = 5'd0;
    w_left = 5'd0;
    w_cur  = 5'd0;
    if ((r_i >= 5'd1) && (r_i <= c_MAX) && (r_j >= 5'd1) && (r_j <= c_MAX)) begin
      w_cur = r_dp[r_i][r_j];
      if ((r_i > 5'd1) && (r_j > 5'd1)) w_diag = r_dp[w_im1][w_jm1];
      if (r_i > 5'd1)                   w_up   = r_dp[w_im1][r_j];
      if (r_j > 5'd1)                   w_left = r_dp[r_i][w_jm1];
    end
  end

  // "Up" wins ties, both for the fill max and for the traceback direction.
  assign w_max  = (w_up >= w_left) ? w_up : w_left;
  assign w_cell = w_match ? (w_diag + 5'd1) : w_max;

  // Traceback writes the matched character into slot dp[i][j]-1.
  assign w_slot      = w_cur - 5'd1;
  assign w_slot_mask = c_TOP_MASK >> {w_slot, 3'b000};

  // Place the matched character in slot 0 and shift it to its final slot.
  always_comb begin
    w_slot_char = '0;
    w_slot_char[c_W-1 -: 8] = w_a_ch;
    w_slot_char = w_slot_char >> {w_slot, 3'b000};
  end

  // DP table write, one cell per FILL cycle; contents need no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_FILL) begin
      r_dp[r_i][r_j] <= w_cell;
    end
  end

  // Control FSM: latch operands, sweep the table, trace back, report.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_str_a   <= '0;
      r_str_b   <= '0;
      r_la      <= 5'd0;
      r_lb      <= 5'd0;
      r_i       <= 5'd0;
      r_j       <= 5'd0;
      r_lcs_len <= 5'd0;
      r_lcs_str <= c_SPACES;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_str_a   <= str_a;
            r_str_b   <= str_b;
            r_la      <= (len_a > c_MAX) ? c_MAX : len_a;
            r_lb      <= (len_b > c_MAX) ? c_MAX : len_b;
            r_lcs_len <= 5'd0;
            r_lcs_str <= c_SPACES;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if ((r_la == 5'd0) || (r_lb == 5'd0)) begin
            r_state <= S_DONE;
          end else begin
            r_i     <= 5'd1;
            r_j     <= 5'd1;
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (r_j == r_lb) begin
            if (r_i == r_la) begin
              // Last cell is being written this cycle: take it from the adder.
              r_lcs_len <= w_cell;
              r_state   <= S_TRACE;
            end else begin
              r_i <= r_i + 5'd1;
              r_j <= 5'd1;
            end
          end else begin
            r_j <= r_j + 5'd1;
          end
        end
        S_TRACE: begin
          if (w_match) begin
            r_lcs_str <= (r_lcs_str & ~w_slot_mask) | w_slot_char;
            r_i       <= r_i - 5'd1;
            r_j       <= r_j - 5'd1;
            if ((r_i == 5'd1) || (r_j == 5'd1)) r_state <= S_DONE;
          end else if (w_up >= w_left) begin
            r_i <= r_i - 5'd1;
            if (r_i == 5'd1) r_state <= S_DONE;
          end else begin
            r_j <= r_j - 5'd1;
            if (r_j == 5'd1) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = (r_state == S_LOAD) || (r_state == S_FILL) || (r_state == S_TRACE);
  assign done    = (r_state == S_DONE);
  assign lcs_len = r_lcs_len;
  assign lcs_str = r_lcs_str;

endmodule

`default_nettype wire

// File: doc/lcs_engine.md
Name: lcs_engine

Overview:
- Computes the longest common subsequence (LCS) of the two strings captured by the text-entry front end.
- Returns the LCS length and the LCS text, formatted for direct display on an LCD row.
- Sits between the string-entry FSM (producer of str1/str2 and their lengths) and the LCD text mux, which consumes the length and string on the result screens.
- Uses a sequential dynamic-programming fill (one cell per clock), then a traceback (one step per clock).

Parameters:
- MAXLEN, 16, maximum characters per input string and per result. Legal range 1..31.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle request to begin a computation; sampled on rising clk.
- str_a  input  8*MAXLEN  string A, ASCII; char k at bits [8*MAXLEN-1-8k -: 8] (first char in MSBs).
- len_a  input  5  number of valid chars in str_a.
- str_b  input  8*MAXLEN  string B, same packing as str_a.
- len_b  input  5  number of valid chars in str_b.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse when results become valid.
- lcs_len  output  5  LCS length.
- lcs_str  output  8*MAXLEN  LCS text, same packing as the inputs, left-justified, padded with 0x20.

Behaviour:

Reset (async):
- State returns to IDLE.
- busy=0, done=0, lcs_len=0, lcs_str = all 0x20.
- The DP table content after reset is don't-care.
- A reset mid-operation aborts immediately; no done pulse follows.

Length handling:
- len_a/len_b greater than MAXLEN are clamped to MAXLEN when latched.

Storage:
- DP table dp[i][j], i,j in 0..MAXLEN, 5 bits per entry.
- Row 0 and column 0 read as 0 without being written.

States:
- IDLE
  - On start: latch str_a, str_b and the clamped lengths (la, lb).
  - Clear lcs_len to 0 and lcs_str to spaces; set busy=1; go to LOAD.
- LOAD (1 cycle)
  - If la==0 or lb==0, go to DONE.
  - Otherwise set i=1, j=1 and go to FILL.
- FILL (exactly la*lb cycles, row-major: j advances fastest)
  - If a[i-1]==b[j-1]: dp[i][j] = dp[i-1][j-1]+1.
  - Else: dp[i][j] = max(dp[i-1][j], dp[i][j-1]).
  - After cell (la,lb): set lcs_len = dp[la][lb], set i=la, j=lb, go to TRACE.
- TRACE (one step per cycle; run while i>0 and j>0)
  - Match a[i-1]==b[j-1]: write a[i-1] into lcs_str char slot dp[i][j]-1, then i--, j--.
  - Mismatch with dp[i-1][j] >= dp[i][j-1]: i-- (tie rule: "up" preferred).
  - Otherwise: j--.
  - When i==0 or j==0, go to DONE.
- DONE (1 cycle)
  - done=1, busy=0, then return to IDLE.

Timing:
- Let E0 be the edge that samples start. done is high in the cycle after edge E(1 + la*lb + T), where T = number of TRACE steps.
- busy is high from the cycle after E0 through the last TRACE cycle.

Other rules:
- start while busy (LOAD/FILL/TRACE/DONE) is ignored; no queuing.
- Inputs str_*/len_* may change freely after E0.
- lcs_len and lcs_str hold their values from done until the next accepted start.
- Slots at index >= lcs_len in lcs_str remain 0x20.
- All arithmetic is unsigned 5-bit; no overflow is possible for MAXLEN <= 31.

Test Plan:
- Typical case: a="abcde"(5), b="ace"(3), start at E0 -> done after E21 (1+15+5); lcs_len=3; lcs_str="ace" followed by 13 spaces; busy high for 21 cycles.
- Tie rule: a="ab", b="ba" -> lcs_len=1; lcs_str="a" plus spaces; done after E1+4+2=E7.
- No common characters: a="abc", b="xyz" -> lcs_len=0; lcs_str all 0x20; done after E13 (1+9+3).
- Full length: a=b="0123456789abcdef" -> lcs_len=16; lcs_str equal to the input; done after E273. Also len_a=20 with the same strings behaves identically (clamp).
- Zero length: len_a=0, len_b=5 -> done after E1; lcs_len=0; spaces. Separately, a start pulse while busy mid-FILL is ignored: exactly one done pulse, results unchanged.
- Reset: assert reset_n=0 during TRACE -> busy, done, lcs_len = 0 and lcs_str = spaces immediately. After release, a new start produces correct results; no stale done pulse appears.
